// File: rtl/io_bus_responder_pkg.sv
// Shared definitions for the memory-mapped I/O responder: data width, register
// offsets, FSM state encodings and the byte-lane mask helper.
package io_bus_responder_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] IO_OFF_OUT  = 5'h00;
    localparam logic [4:0] IO_OFF_IN   = 5'h04;
    localparam logic [4:0] IO_OFF_CHG  = 5'h08;
    localparam logic [4:0] IO_OFF_SET  = 5'h0C;
    localparam logic [4:0] IO_OFF_CLR  = 5'h10;
    localparam logic [4:0] IO_OFF_MASK = 5'h14;

    typedef enum logic [1:0] {
        IO_ST_IDLE = 2'd0,
        IO_ST_WAIT = 2'd1,
        IO_ST_RESP = 2'd2
    } io_state_t;

    // Expands the four store byte enables into a per-bit write mask.
    function automatic logic [XLEN-1:0] lane_mask(input logic [3:0] be);
        logic [XLEN-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/io_input_synchronizer.sv
// Multi-flop synchronizer for the external input bus; also keeps the previous
// synchronized value so the parent can detect per-bit changes.
module io_input_synchronizer #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] prev_out
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[STAGES-1];
        end
    end

    assign sync_out = stage_q[STAGES-1];
    assign prev_out = prev_q;

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder: OUT/IN/CHG/OUT_SET/OUT_CLR registers behind a
// valid/ready request port. Optional IRQ_MASK register and irq output when
// IO_BUS_IRQ_EN is defined.
module io_bus_responder
    import io_bus_responder_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_8000,
    parameter int              WAIT_STATES = 0,
    parameter logic [XLEN-1:0] OUT_RESET   = 32'h0,
    parameter int              SYNC_STAGES = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [3:0]      req_byte_en,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_error,
    input  logic [XLEN-1:0] io_input_bus,
    output logic [XLEN-1:0] io_output_bus,
`ifdef IO_BUS_IRQ_EN
    output logic            irq,
`endif
    output logic [1:0]      dbg_state
);

    // Handshake: a request is accepted on a rising edge where req_valid and
    // req_ready are both high; exactly one rsp_valid pulse follows each accept
    // and the responder never waits on the requester.

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    io_state_t       state_q, state_d;
    logic            ready_en_q;
    logic            lat_write_q;
    logic [XLEN-1:0] lat_addr_q, lat_wdata_q;
    logic [3:0]      lat_be_q;
    logic [3:0]      wait_cnt_q;
    logic [XLEN-1:0] out_q, out_d;
    logic [XLEN-1:0] chg_q, chg_d;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic [XLEN-1:0] in_sync, in_prev;
    logic            accept;

    logic            cur_write;
    logic [XLEN-1:0] cur_addr;
    logic [XLEN-1:0] rd_val, load_val;
    logic            bad;
    logic            do_store;
    logic [4:0]      st_off;
    logic [XLEN-1:0] st_bits;

`ifdef IO_BUS_IRQ_EN
    logic [XLEN-1:0] irq_mask_q, irq_mask_d;
    logic            irq_q;
`endif

    io_input_synchronizer #(
        .WIDTH  (XLEN),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (io_input_bus),
        .sync_out (in_sync),
        .prev_out (in_prev)
    );

    assign accept = req_valid && req_ready;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IO_ST_IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IO_ST_IDLE: if (accept) state_d = (WAIT_STATES > 0) ? IO_ST_WAIT : IO_ST_RESP;
            IO_ST_WAIT: if (wait_cnt_q == 4'd0) state_d = IO_ST_RESP;
            IO_ST_RESP: state_d = IO_ST_IDLE;
            default:    state_d = IO_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state_q == IO_ST_IDLE) && ready_en_q;
        rsp_valid = (state_q == IO_ST_RESP);
        dbg_state = state_q;
    end

    // With no wait states the response is formed on the accept edge itself, so
    // decode looks at the live request in IDLE and the latched one afterwards.
    assign cur_write = (state_q == IO_ST_IDLE) ? req_write : lat_write_q;
    assign cur_addr  = (state_q == IO_ST_IDLE) ? req_addr  : lat_addr_q;

    always_comb begin
        rd_val = '0;
        bad    = 1'b0;
        if (cur_addr[1:0] != 2'b00 || cur_addr[XLEN-1:5] != BASE_ADDR[XLEN-1:5]) begin
            bad = 1'b1;
        end else begin
            case (cur_addr[4:0])
                IO_OFF_OUT: rd_val = out_q;
                IO_OFF_IN: begin
                    rd_val = in_sync;
                    bad    = cur_write;
                end
                IO_OFF_CHG: rd_val = chg_q;
                IO_OFF_SET, IO_OFF_CLR: rd_val = '0;
`ifdef IO_BUS_IRQ_EN
                IO_OFF_MASK: rd_val = irq_mask_q;
`endif
                default: bad = 1'b1;
            endcase
        end
        load_val = (bad || cur_write) ? '0 : rd_val;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_be_q    <= '0;
            wait_cnt_q  <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                lat_write_q <= req_write;
                lat_addr_q  <= req_addr;
                lat_wdata_q <= req_wdata;
                lat_be_q    <= req_byte_en;
                wait_cnt_q  <= WAIT_LOAD;
            end else if (state_q == IO_ST_WAIT && wait_cnt_q != 4'd0) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end
            rdata_q <= (state_d == IO_ST_RESP) ? load_val : '0;
            err_q   <= (state_d == IO_ST_RESP) ? bad : 1'b0;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_error = err_q;

    // Stores commit on the edge that ends RESP; err_q already vetoes faults.
    assign do_store = (state_q == IO_ST_RESP) && lat_write_q && !err_q;
    assign st_off   = lat_addr_q[4:0];
    assign st_bits  = lat_wdata_q & lane_mask(lat_be_q);

    always_comb begin
        out_d = out_q;
        chg_d = chg_q;
`ifdef IO_BUS_IRQ_EN
        irq_mask_d = irq_mask_q;
`endif
        if (do_store) begin
            case (st_off)
                IO_OFF_OUT: out_d = (out_q & ~lane_mask(lat_be_q)) | st_bits;
                IO_OFF_SET: out_d = out_q | st_bits;
                IO_OFF_CLR: out_d = out_q & ~st_bits;
                IO_OFF_CHG: chg_d = chg_q & ~st_bits;
`ifdef IO_BUS_IRQ_EN
                IO_OFF_MASK: irq_mask_d = (irq_mask_q & ~lane_mask(lat_be_q)) | st_bits;
`endif
                default: ;
            endcase
        end
        // Hardware set is applied after the clear so a coincident set wins.
        chg_d = chg_d | (in_sync ^ in_prev);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q <= OUT_RESET;
            chg_q <= '0;
        end else begin
            out_q <= out_d;
            chg_q <= chg_d;
        end
    end

    assign io_output_bus = out_q;

`ifdef IO_BUS_IRQ_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= |(chg_q & irq_mask_q);
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder: directed register-map scenarios,
// randomized accesses against a register-level model, and a reset-abort case.
module tb_io_bus_responder;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic        valid0, valid1;
    logic        ready0, ready1;
    logic        req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_byte_en;
    logic        rsp_valid0, rsp_valid1;
    logic [31:0] rdata0, rdata1;
    logic        err0, err1;
    logic [31:0] io_in;
    logic [31:0] io_out0, io_out1;
    logic [1:0]  dbg0, dbg1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] out_m, chg_m, in_m;

    always #5 clk = ~clk;

    io_bus_responder dut0 (
        .clock(clk), .reset(rst0), .req_valid(valid0), .req_ready(ready0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_byte_en(req_byte_en), .rsp_valid(rsp_valid0), .rsp_rdata(rdata0),
        .rsp_error(err0), .io_input_bus(io_in), .io_output_bus(io_out0),
        .dbg_state(dbg0)
    );

    io_bus_responder #(.WAIT_STATES(3), .OUT_RESET(32'h0000_00C3)) dut1 (
        .clock(clk), .reset(rst1), .req_valid(valid1), .req_ready(ready1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_byte_en(req_byte_en), .rsp_valid(rsp_valid1), .rsp_rdata(rdata1),
        .rsp_error(err1), .io_input_bus(io_in), .io_output_bus(io_out1),
        .dbg_state(dbg1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one request on the selected DUT; called 1 time unit after an edge.
    task automatic do_req(input int sel, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic [31:0] out_at_rsp, output logic [31:0] out_after);
        bit got;
        rd = '0; er = 1'b0; lat = 0; out_at_rsp = '0; out_after = '0;
        req_write = wr; req_addr = addr; req_wdata = wd; req_byte_en = be;
        if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if ((sel == 0) ? ready0 : ready1) got = 1;
            tick(1);
        end
        valid0 = 1'b0; valid1 = 1'b0;
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if ((sel == 0) ? rsp_valid0 : rsp_valid1) begin
                got = 1;
                rd = (sel == 0) ? rdata0 : rdata1;
                er = (sel == 0) ? err0 : err1;
                out_at_rsp = (sel == 0) ? io_out0 : io_out1;
            end else begin
                tick(1);
                lat++;
            end
        end
        if (!got) begin
            check("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        tick(1);
        out_after = (sel == 0) ? io_out0 : io_out1;
    endtask

    // Register-level reference model of dut0 (base 0x8000, settled inputs).
    task automatic model_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] exp_rd, output logic exp_err);
        logic [31:0] off, m;
        off = addr - 32'h8000;
        m = 0;
        for (int i = 0; i < 4; i++) if (be[i]) m = m + (32'hFF << (8 * i));
        exp_rd = 0;
        exp_err = (addr % 4 != 0) || (addr < 32'h8000) || (addr >= 32'h8020)
                  || (off >= 32'h14) || (wr && off == 32'h4);
        if (exp_err) return;
        if (!wr) begin
            if (off == 32'h0) exp_rd = out_m;
            if (off == 32'h4) exp_rd = in_m;
            if (off == 32'h8) exp_rd = chg_m;
        end else begin
            if (off == 32'h0)  out_m = (out_m & ~m) | (wd & m);
            if (off == 32'hC)  out_m = out_m | (wd & m);
            if (off == 32'h10) out_m = out_m & ~(wd & m);
            if (off == 32'h8)  chg_m = chg_m & ~(wd & m);
        end
    endtask

    task automatic model_check(input string tag, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] rd, oa, ob, exp_rd, old_out;
        logic        er, exp_err;
        int          lat;
        old_out = out_m;
        model_req(wr, addr, wd, be, exp_rd, exp_err);
        do_req(0, wr, addr, wd, be, rd, er, lat, ob, oa);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_error"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, "_latency"}, lat, 0);
        check({tag, "_out_at_rsp"}, ob, old_out);
        check({tag, "_out_after"}, oa, out_m);
    endtask

    task automatic change_inputs(input logic [31:0] nv);
        chg_m = chg_m | (in_m ^ nv);
        in_m = nv;
        io_in = nv;
        tick(4);
    endtask

    initial begin
        logic [31:0] rd, oa, ob, addr;
        logic        er;
        int          lat, k, seen;

        rst0 = 1'b0; rst1 = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
        req_write = 1'b0; req_addr = '0; req_wdata = '0; req_byte_en = '0; io_in = '0;
        out_m = 32'h0; chg_m = 32'h0; in_m = 32'h0;

        tick(3);
        check("rst_ready", ready0, 0);
        check("rst_rsp_valid", rsp_valid0, 0);
        check("rst_rdata", rdata0, 0);
        check("rst_error", err0, 0);
        check("rst_out", io_out0, 32'h0);
        check("rst_out1", io_out1, 32'h0000_00C3);
        rst0 = 1'b1; rst1 = 1'b1;
        #1;
        check("ready_before_edge", ready0, 0);
        tick(1);
        check("ready_after_edge", ready0, 1);

        model_check("load_out", 1'b0, 32'h8000, 32'h0, 4'h0);
        model_check("store_out", 1'b1, 32'h8000, 32'hA5A5_A5A5, 4'b0011);
        check("out_a5a5", io_out0, 32'h0000_A5A5);
        model_check("store_set", 1'b1, 32'h800C, 32'h0000_FF00, 4'hF);
        check("out_ffa5", io_out0, 32'h0000_FFA5);
        model_check("store_clr", 1'b1, 32'h8010, 32'h0000_0005, 4'hF);
        check("out_ffa0", io_out0, 32'h0000_FFA0);

        // Input change: a load accepted on the first edge still sees the old value.
        io_in = 32'h1;
        do_req(0, 1'b0, 32'h8004, 32'h0, 4'h0, rd, er, lat, ob, oa);
        check("in_too_early", rd, 32'h0);
        do_req(0, 1'b0, 32'h8004, 32'h0, 4'h0, rd, er, lat, ob, oa);
        check("in_after_sync", rd, 32'h1);
        in_m = 32'h1; chg_m = 32'h1;
        tick(2);
        model_check("chg_after_rise", 1'b0, 32'h8008, 32'h0, 4'h0);

        // W1C lands on the same edge the hardware sets bit 0 again.
        io_in = 32'h0;
        tick(1);
        do_req(0, 1'b1, 32'h8008, 32'h1, 4'hF, rd, er, lat, ob, oa);
        in_m = 32'h0;
        tick(2);
        do_req(0, 1'b0, 32'h8008, 32'h0, 4'h0, rd, er, lat, ob, oa);
        check("chg_set_wins", rd, 32'h1);
        model_check("chg_w1c", 1'b1, 32'h8008, 32'h1, 4'hF);
        model_check("chg_cleared", 1'b0, 32'h8008, 32'h0, 4'h0);

        model_check("err_misaligned", 1'b0, 32'h8002, 32'h0, 4'h0);
        model_check("err_unmapped", 1'b0, 32'h8018, 32'h0, 4'h0);
        model_check("err_store_in", 1'b1, 32'h8004, 32'hFFFF_FFFF, 4'hF);
        model_check("err_irq_mask", 1'b1, 32'h8014, 32'hFFFF_FFFF, 4'hF);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) change_inputs($urandom);
            k = $urandom_range(0, 9);
            if (k < 8)       addr = 32'h8000 + 4 * k;
            else if (k == 8) addr = 32'h8000 + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
            else             addr = ($urandom_range(0, 1) != 0) ? 32'h7FE0 + 4 * $urandom_range(0, 7)
                                                                 : 32'h8000 + 32 * $urandom_range(1, 200);
            model_check($sformatf("rnd%0d", it), $urandom_range(0, 1) != 0, addr, $urandom,
                        4'($urandom_range(0, 15)));
        end

        // Reset during the wait phase of a store on the WAIT_STATES=3 instance.
        req_write = 1'b1; req_addr = 32'h8000; req_wdata = 32'h1234; req_byte_en = 4'hF;
        valid1 = 1'b1;
        check("dut1_ready", ready1, 1);
        tick(1);
        valid1 = 1'b0;
        tick(1);
        rst1 = 1'b0;
        #1;
        check("abort_rsp_valid", rsp_valid1, 0);
        check("abort_ready", ready1, 0);
        check("abort_out", io_out1, 32'h0000_00C3);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (rsp_valid1) seen++;
        end
        rst1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (rsp_valid1) seen++;
        end
        check("abort_no_rsp", seen, 0);
        check("abort_out_kept", io_out1, 32'h0000_00C3);
        do_req(1, 1'b0, 32'h8000, 32'h0, 4'h0, rd, er, lat, ob, oa);
        check("ws3_rdata", rd, 32'h0000_00C3);
        check("ws3_error", er, 0);
        check("ws3_latency", lat, 3);
        do_req(1, 1'b1, 32'h8000, 32'h5A5A_0000, 4'b1100, rd, er, lat, ob, oa);
        check("ws3_store_latency", lat, 3);
        check("ws3_out_at_rsp", ob, 32'h0000_00C3);
        check("ws3_out_after", oa, 32'h5A5A_00C3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
